dibit_dds_modulator: RTL and testbench

- Downstream consumer of the 2-bit symbol register (the dibit acquisition/hold stage, 1 kHz symbol rate). Turns each dibit into a sampled carrier waveform using a phase-accumulator (DDS) with a sine LUT.
- Runtime-selectable scheme: 4-ASK, 4-FSK, QPSK or idle.
- Drives the DAC/PWM output stage with an 8-bit offset-binary sample stream.

---
 rtl/dibit_dds_modulator_if.sv | 11 +
 rtl/dibit_dds_modulator.sv | 174 +++++++++++++++++
 tb/tb_dibit_dds_modulator.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dibit_dds_modulator_if.sv
// Symbol/mode inputs and DAC sample stream of the dibit DDS modulator.
interface dibit_dds_modulator_if;
  logic [1:0] sym_in;
  logic [1:0] mode;
  logic [7:0] dac_out;
  logic       sample_valid;
  logic       sym_tick;

  modport master (output sym_in, mode, input dac_out, sample_valid, sym_tick);
  modport slave  (input sym_in, mode, output dac_out, sample_valid, sym_tick);
endinterface

// File: rtl/dibit_dds_modulator.sv
// DDS carrier modulator: dibit symbols become 4-ASK, 4-FSK or QPSK sine samples
// on an 8-bit offset-binary DAC stream, one sample every SAMP_DIV clocks.
module dibit_dds_modulator #(
  parameter int unsigned SAMP_DIV    = 50,
  parameter int unsigned SYM_SAMPLES = 1000,
  parameter int unsigned PHASE_W     = 16,
  parameter int unsigned FCW_BASE    = 524,
  parameter int unsigned FCW_DEV     = 131
) (
  input  logic clk,
  input  logic rst,
  dibit_dds_modulator_if.slave bus
);

  localparam int unsigned SCNT_W = (SAMP_DIV > 1) ? $clog2(SAMP_DIV) : 1;
  localparam int unsigned YCNT_W = (SYM_SAMPLES > 1) ? $clog2(SYM_SAMPLES) : 1;

  localparam logic [1:0] MODE_ASK  = 2'b00;
  localparam logic [1:0] MODE_FSK  = 2'b01;
  localparam logic [1:0] MODE_QPSK = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64
  localparam logic [6:0] QTAB [65] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
    7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
    7'd60,  7'd63,  7'd65,  7'd68,  7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
    7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
    7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
    7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [1:0]         sym_s1, sym_s2, mode_s1, mode_s2;
  logic [SCNT_W-1:0]  samp_cnt;
  logic [YCNT_W-1:0]  sym_cnt;
  logic [1:0]         cur_sym, cur_mode;
  logic [PHASE_W-1:0] acc;

  logic [7:0]         s1_idx;
  logic [1:0]         s1_sym, s1_mode;
  logic               s1_vld;
  logic [7:0]         s2_lut;
  logic [1:0]         s2_sym, s2_mode;
  logic               s2_vld;

  logic               tick_c, boundary_c;
  logic [1:0]         eff_sym_c, eff_mode_c;
  logic [PHASE_W-1:0] fcw_c;
  logic [7:0]         offset_c, idx_c;
  logic [6:0]         qidx_c, mag_c;
  logic [7:0]         sine_c;
  logic [2:0]         mult_c;
  logic signed [9:0]  prod_c;
  logic [7:0]         scaled_c, dac_c;

  // Two-flop synchronisers for the asynchronous symbol and mode inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_s1  <= 2'b00;
      sym_s2  <= 2'b00;
      mode_s1 <= 2'b00;
      mode_s2 <= 2'b00;
    end else begin
      sym_s1  <= bus.sym_in;
      sym_s2  <= sym_s1;
      mode_s1 <= bus.mode;
      mode_s2 <= mode_s1;
    end
  end

  // Sample tick, symbol boundary, and the symbol/mode in force for this tick
  always_comb begin
    tick_c     = (samp_cnt == SCNT_W'(SAMP_DIV - 1));
    boundary_c = tick_c && (sym_cnt == '0);
    eff_sym_c  = boundary_c ? sym_s2 : cur_sym;
    eff_mode_c = boundary_c ? mode_s2 : cur_mode;
  end

  // Frequency word and QPSK Gray-mapped phase offset feeding the LUT index
  always_comb begin
    fcw_c    = PHASE_W'(FCW_BASE);
    offset_c = 8'd0;
    if (eff_mode_c == MODE_FSK) begin
      fcw_c = PHASE_W'(FCW_BASE) + PHASE_W'(FCW_DEV) * PHASE_W'(eff_sym_c);
    end
    if (eff_mode_c == MODE_QPSK) begin
      case (eff_sym_c)
        2'b01:   offset_c = 8'd64;
        2'b11:   offset_c = 8'd128;
        2'b10:   offset_c = 8'd192;
        default: offset_c = 8'd0;
      endcase
    end
    idx_c = acc[PHASE_W-1 -: 8] + offset_c;
  end

  // Sample/symbol counters, symbol latch, phase accumulator and stage 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_cnt <= '0;
      sym_cnt  <= '0;
      cur_sym  <= 2'b00;
      cur_mode <= MODE_IDLE;
      acc      <= '0;
      bus.sym_tick <= 1'b0;
      s1_idx   <= 8'd0;
      s1_sym   <= 2'b00;
      s1_mode  <= 2'b00;
      s1_vld   <= 1'b0;
    end else begin
      samp_cnt     <= tick_c ? '0 : samp_cnt + SCNT_W'(1);
      bus.sym_tick <= boundary_c;
      s1_vld       <= tick_c;
      if (boundary_c) begin
        cur_sym  <= sym_s2;
        cur_mode <= mode_s2;
      end
      if (tick_c) begin
        sym_cnt <= (sym_cnt == YCNT_W'(SYM_SAMPLES - 1)) ? '0 : sym_cnt + YCNT_W'(1);
        acc     <= (eff_mode_c == MODE_IDLE) ? '0 : acc + fcw_c;
        s1_idx  <= idx_c;
        s1_sym  <= eff_sym_c;
        s1_mode <= eff_mode_c;
      end
    end
  end

  // Quarter-wave sine lookup with mirroring and sign restoration
  always_comb begin
    qidx_c = s1_idx[6] ? (7'd64 - {1'b0, s1_idx[5:0]}) : {1'b0, s1_idx[5:0]};
    mag_c  = QTAB[qidx_c];
    sine_c = s1_idx[7] ? (8'd0 - {1'b0, mag_c}) : {1'b0, mag_c};
  end

  // Stage 2: registered LUT value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_lut  <= 8'd0;
      s2_sym  <= 2'b00;
      s2_mode <= 2'b00;
      s2_vld  <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_lut  <= sine_c;
        s2_sym  <= s1_sym;
        s2_mode <= s1_mode;
      end
    end
  end

  // ASK scaling (x4 then >>>2 is identity for the other modes) and offset-binary
  always_comb begin
    mult_c   = (s2_mode == MODE_ASK) ? (3'(s2_sym) + 3'd1) : 3'd4;
    prod_c   = $signed({{2{s2_lut[7]}}, s2_lut}) * $signed({7'd0, mult_c});
    scaled_c = 8'(prod_c >>> 2);
    dac_c    = (s2_mode == MODE_IDLE) ? 8'd128 : {~scaled_c[7], scaled_c[6:0]};
  end

  // Stage 3: output sample register, held between samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dac_out      <= 8'd128;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= s2_vld;
      if (s2_vld) begin
        bus.dac_out <= dac_c;
      end
    end
  end

endmodule

// File: tb/tb_dibit_dds_modulator.sv
// Self-checking bench for dibit_dds_modulator against a real-arithmetic DDS model.
module tb_dibit_dds_modulator;

  localparam int SAMP_DIV = 50;
  localparam int SYM      = 12;
  localparam int FCW_BASE = 524;
  localparam int FCW_DEV  = 131;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dibit_dds_modulator_if bus();

  dibit_dds_modulator #(
    .SAMP_DIV(SAMP_DIV), .SYM_SAMPLES(SYM), .PHASE_W(16),
    .FCW_BASE(FCW_BASE), .FCW_DEV(FCW_DEV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // sym_tick pulses observed since time zero
  int st_count = 0;
  always @(negedge clk) if (bus.sym_tick === 1'b1) st_count++;

  // Reference model state
  int qoff [4] = '{0, 64, 192, 128};
  int m_acc, m_sym, m_mode, m_n;
  int m_bounds = 0;
  int drv_sym, drv_mode;
  logic [7:0] prev_dac;
  logic [7:0] last_dac;
  bit after_rst;

  function automatic int ref_sample(int acc, int sym, int mode);
    int idx, lut, prod;
    real r;
    if (mode == 3) return 128;
    idx = acc / 256;
    if (mode == 2) idx = idx + qoff[sym];
    idx = idx % 256;
    r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(idx) / 256.0);
    lut = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    if (mode == 0) begin
      prod = lut * (sym + 1);
      lut = (prod >= 0) ? prod / 4 : -((-prod + 3) / 4);
    end
    return lut + 128;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic drive(input int s, input int m);
    bus.sym_in = 2'(s);
    bus.mode   = 2'(m);
    drv_sym    = s;
    drv_mode   = m;
  endtask

  task automatic model_reset();
    m_acc = 0; m_sym = 0; m_mode = 3; m_n = 0;
    prev_dac = 8'd128;
    after_rst = 1'b1;
  endtask

  task automatic do_reset(input int s, input int m);
    @(negedge clk);
    rst = 1'b0;
    drive(s, m);
    #1;
    chk("rst_dac", bus.dac_out, 128);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_sym_tick", bus.sym_tick, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Wait for the next sample and compare everything the model predicts for it
  task automatic next_sample();
    int n, st_at, expv, fcw;
    bit hold_ok;
    n = 0; st_at = -1; hold_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (bus.sym_tick === 1'b1 && st_at < 0) st_at = n;
      if (bus.sample_valid !== 1'b1 && bus.dac_out !== prev_dac) hold_ok = 1'b0;
    end while (bus.sample_valid !== 1'b1 && n < 100);
    chk("valid_seen", bus.sample_valid, 1);
    if (bus.sample_valid !== 1'b1) return;
    chk("sample_gap", n, after_rst ? 52 : 50);
    chk("dac_hold", hold_ok, 1);
    if (m_n % SYM == 0) begin
      m_sym = drv_sym;
      m_mode = drv_mode;
      m_bounds++;
      chk("sym_tick_pos", st_at, after_rst ? 50 : 48);
    end else begin
      chk("no_sym_tick", st_at, -1);
    end
    after_rst = 1'b0;
    expv = ref_sample(m_acc, m_sym, m_mode);
    chk("dac_out", bus.dac_out, expv);
    fcw = (m_mode == 1) ? FCW_BASE + FCW_DEV * m_sym : FCW_BASE;
    m_acc = (m_mode == 3) ? 0 : (m_acc + fcw) % 65536;
    m_n++;
    chk("acc", dut.acc, m_acc);
    chk("sym_tick_count", st_count, m_bounds);
    last_dac = bus.dac_out;
    prev_dac = 8'(expv);
  endtask

  task automatic run(input int n);
    repeat (n) next_sample();
  endtask

  int q_sym [4] = '{1, 2, 0, 3};
  int q_exp [4] = '{255, 1, 128, 128};

  initial begin
    drive(0, 3);
    model_reset();

    // Idle after reset: flat 128, regular ticks, accumulator parked at 0
    do_reset(int'($urandom_range(0, 3)), 3);
    run(2 * SYM + 1);

    // QPSK first sample from zero phase for each dibit
    for (int i = 0; i < 4; i++) begin
      do_reset(q_sym[i], 2);
      next_sample();
      chk("qpsk_first", last_dac, q_exp[i]);
      run(SYM);
    end

    // 4-ASK amplitude levels
    do_reset(0, 0);
    run(SYM);
    drive(3, 0);
    run(SYM);
    drive(1, 0);
    run(SYM);

    // FSK sym 11, then a mid-symbol change that must wait for the boundary
    do_reset(3, 1);
    run(2);
    chk("fsk_acc2", dut.acc, 1834);
    drive(0, 1);
    run(SYM);

    // Accumulator wrap over 72 samples of FSK sym 11
    do_reset(3, 1);
    run(72);
    chk("wrap_acc", dut.acc, (72 * 917) % 65536);

    // Random symbols and modes, changed at arbitrary sample positions
    repeat (200) begin
      if ($urandom_range(0, 5) == 0) drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      next_sample();
    end

    // One-clock reset in the middle of an active QPSK symbol
    drive(1, 2);
    run(SYM + 1);
    repeat ($urandom_range(1, 40)) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_dac", bus.dac_out, 128);
    chk("mid_rst_valid", bus.sample_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_acc", dut.acc, 0);
    run(SYM + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
